// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch stage PC owner, single-outstanding imem reader and decode FIFO (optional FETCH_PERF_EN counters)
module fetch_sequencer #(
    parameter int                 ADDR_W    = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  cur_pc,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
);

    localparam int                PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [ADDR_W-1:0]   buf_pc    [BUF_DEPTH];
    logic [INSTR_W-1:0]  buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_after_push;

    logic                push;
    logic                pop;

    assign instr_valid = (count_q != '0);
    assign instruction = buf_instr[rd_ptr_q];
    assign instr_pc    = buf_pc[rd_ptr_q];
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign cur_pc      = pc_q;

    // A redirect flushes the FIFO, so it also cancels any pop in that cycle.
    assign pop              = instr_valid & instr_ready & ~pc_src;
    assign count_after_push = count_q + CNT_W'(1) - CNT_W'(pop);

    // State, PC and request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state, next-PC and push decision; request is registered so it is stable until ack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pc_src) begin
                    pc_d    = branch_target;
                    state_d = run ? S_REQ : S_IDLE;
                end else if (run && (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pc_src) begin
                    pc_d    = branch_target;
                    state_d = run ? S_REQ : S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_src) begin
                    pc_d = branch_target;
                    if (mem_ack) begin
                        state_d = run ? S_REQ : S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (mem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = (run && (count_after_push < DEPTH_C)) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (pc_src) begin
                    pc_d = branch_target;
                end
                if (mem_ack) begin
                    state_d = run ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d  = (state_d != S_IDLE);
        addr_d = (state_d == S_REQ) ? pc_d : addr_q;
    end

    // Instruction FIFO; flush on redirect has priority over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else if (pc_src) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr_q]    <= pc_q;
                buf_instr[wr_ptr_q] <= mem_rdata;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, flush_q;
    logic        drop_resp;
    logic [33:0] flush_sum;

    // Only a redirect taken in WAIT abandons an in-flight response; DROP already counted it.
    assign drop_resp = pc_src && (state_q == S_WAIT);
    assign flush_sum = {2'b00, flush_q} + 34'(count_q) + 34'(drop_resp);

    // Saturating stall and flush counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (instr_valid && !instr_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (pc_src) begin
                flush_q <= (flush_sum > 34'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : flush_sum[31:0];
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        pc_src = 1'b0;
    logic [63:0] branch_target = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [63:0] cur_pc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W   (64),
        .INSTR_W  (32),
        .RESET_PC (64'h0),
        .BUF_DEPTH(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .cur_pc       (cur_pc),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_pc;
    int          age, cur_lat, lat_lo, lat_hi;
    logic [63:0] acc_q[$];
    logic [63:0] dpc_q[$];
    int          n_deliv, cyc, first_valid;
    longint      stall_m;
    int          n0, nd;
    bit          saw_valid, reached;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic ack_now, src_now, req_now, pop_now;
        ack_now   = mem_req && (age >= 1 + cur_lat);
        mem_ack   = ack_now;
        mem_rdata = ack_now ? mem_addr[31:0] : $urandom();
        src_now   = pc_src;
        req_now   = mem_req;
        pop_now   = instr_valid && instr_ready && !pc_src;
        if (ack_now) acc_q.push_back(mem_addr);
        if (instr_valid && first_valid < 0) first_valid = cyc;
        if (instr_valid && !instr_ready) stall_m++;
        if (pop_now) begin
            check("deliv_pc", instr_pc, exp_pc);
            check("deliv_data", {32'h0, instruction}, {32'h0, exp_pc[31:0]});
            dpc_q.push_back(instr_pc);
            exp_pc = exp_pc + 64'd4;
            n_deliv++;
        end
        if (src_now) exp_pc = branch_target;
        @(posedge clk);
        #1;
        cyc++;
        mem_ack = 1'b0;
        if (ack_now) begin
            age     = 0;
            cur_lat = $urandom_range(lat_hi, lat_lo);
        end else if (src_now) begin
            age = 0;
        end else if (req_now) begin
            age++;
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        run         = 1'b0;
        pc_src      = 1'b0;
        instr_ready = 1'b0;
        mem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        age         = 0;
        exp_pc      = 64'h0;
        acc_q.delete();
        dpc_q.delete();
        n_deliv     = 0;
        stall_m     = 0;
        first_valid = -1;
        cyc         = 0;
        cur_lat     = $urandom_range(lat_hi, lat_lo);
        reset       = 1'b1;
    endtask

    initial begin
        lat_lo = 0;
        lat_hi = 0;
        #1;
        reset = 1'b0;
        #12;
        check("rst_req", {63'h0, mem_req}, 64'h0);
        check("rst_addr", mem_addr, 64'h0);
        check("rst_valid", {63'h0, instr_valid}, 64'h0);
        check("rst_instr", {32'h0, instruction}, 64'h0);
        check("rst_ipc", instr_pc, 64'h0);
        check("rst_pc", cur_pc, 64'h0);
        check("rst_stall", {32'h0, stall_cnt}, 64'h0);
        check("rst_flush", {32'h0, flush_cnt}, 64'h0);

        // Zero-wait streaming from reset.
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        repeat (8) tick();
        check("t1_first_valid", 64'(first_valid), 64'd3);
        check("t1_nacc", 64'(acc_q.size() >= 3), 64'd1);
        if (acc_q.size() >= 3) begin
            check("t1_addr0", acc_q[0], 64'h0);
            check("t1_addr1", acc_q[1], 64'h4);
            check("t1_addr2", acc_q[2], 64'h8);
        end
        check("t1_ndeliv", 64'(dpc_q.size() >= 2), 64'd1);
        if (dpc_q.size() >= 2) begin
            check("t1_dpc0", dpc_q[0], 64'h0);
            check("t1_dpc1", dpc_q[1], 64'h4);
        end

        // Back-pressure: FIFO fills, then one pop frees exactly one slot.
        do_reset();
        run = 1'b1;
        repeat (12) tick();
        check("t2_req_idle", {63'h0, mem_req}, 64'h0);
        check("t2_pc", cur_pc, 64'h8);
        check("t2_valid", {63'h0, instr_valid}, 64'h1);
        n0 = acc_q.size();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (8) tick();
        check("t2_one_req", 64'(acc_q.size() - n0), 64'd1);
        check("t2_req_addr", acc_q[acc_q.size()-1], 64'h8);
        check("t2_pc_after", cur_pc, 64'hC);
        check("t2_req_after", {63'h0, mem_req}, 64'h0);

        // Redirect while waiting on a 3-cycle memory.
        lat_lo = 3;
        lat_hi = 3;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 60 && !(instr_valid && mem_req && age >= 1 && age < 1 + cur_lat); i++) tick();
        reached = instr_valid && mem_req && age >= 1 && age < 1 + cur_lat;
        check("t3_reach_wait", {63'h0, reached}, 64'h1);
        n0 = acc_q.size();
        pc_src = 1'b1;
        branch_target = 64'h100;
        tick();
        pc_src = 1'b0;
        check("t3_flushed", {63'h0, instr_valid}, 64'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 60 && acc_q.size() < n0 + 2; i++) begin
            if (instr_valid) saw_valid = 1'b1;
            tick();
        end
        check("t3_no_stale", {63'h0, saw_valid}, 64'h0);
        check("t3_nacc", 64'(acc_q.size()), 64'(n0 + 2));
        if (acc_q.size() >= n0 + 2) begin
            check("t3_stale_addr", acc_q[n0], 64'h4);
            check("t3_new_addr", acc_q[n0+1], 64'h100);
        end
        check("t3_ipc", instr_pc, 64'h100);
        check("t3_instr", {32'h0, instruction}, 64'h100);
`ifdef FETCH_PERF_EN
        check("t3_flush_cnt", {32'h0, flush_cnt}, 64'd2);
        check("t3_stall_cnt", {32'h0, stall_cnt}, 64'(stall_m));
`else
        check("t3_flush_cnt", {32'h0, flush_cnt}, 64'd0);
`endif

        // Redirect in the same cycle as the ack.
        lat_lo = 2;
        lat_hi = 2;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && !(acc_q.size() >= 2 && mem_req && age >= 1 + cur_lat); i++) tick();
        reached = acc_q.size() >= 2 && mem_req && age >= 1 + cur_lat;
        check("t4_reach_ack", {63'h0, reached}, 64'h1);
        n0 = acc_q.size();
        nd = n_deliv;
        pc_src = 1'b1;
        branch_target = 64'h40;
        tick();
        pc_src = 1'b0;
        check("t4_nopush", {63'h0, instr_valid}, 64'h0);
        for (int i = 0; i < 60 && n_deliv <= nd; i++) tick();
        check("t4_nacc", 64'(acc_q.size() >= n0 + 2), 64'd1);
        if (acc_q.size() >= n0 + 2) check("t4_next_addr", acc_q[n0+1], 64'h40);
        check("t4_deliv_pc", dpc_q[dpc_q.size()-1], 64'h40);

        // Asynchronous reset in the middle of WAIT.
        lat_lo = 3;
        lat_hi = 3;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && !(acc_q.size() >= 1 && mem_req && age >= 1 && age < 1 + cur_lat); i++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("t5_req", {63'h0, mem_req}, 64'h0);
        check("t5_pc", cur_pc, 64'h0);
        check("t5_valid", {63'h0, instr_valid}, 64'h0);
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && acc_q.size() < 1; i++) tick();
        check("t5_restart", acc_q.size() >= 1 ? acc_q[0] : 64'hDEAD, 64'h0);

        // PC wrap at the top of the address space.
        lat_lo = 0;
        lat_hi = 0;
        do_reset();
        run = 1'b1;
        instr_ready = 1'b1;
        pc_src = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        pc_src = 1'b0;
        for (int i = 0; i < 60 && acc_q.size() < 2; i++) tick();
        check("t6_nacc", 64'(acc_q.size() >= 2), 64'd1);
        if (acc_q.size() >= 2) begin
            check("t6_top", acc_q[0], 64'hFFFF_FFFF_FFFF_FFFC);
            check("t6_wrap", acc_q[1], 64'h0);
        end

        // Random traffic against the PC-sequence model.
        lat_lo = 0;
        lat_hi = 3;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            run         = ($urandom_range(7, 0) != 0);
            instr_ready = ($urandom_range(2, 0) != 0);
            pc_src      = ($urandom_range(15, 0) == 0);
            if ($urandom_range(3, 0) == 0)
                branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(3, 0) << 2);
            else
                branch_target = {$urandom(), $urandom()} & ~64'h3;
            tick();
        end
        pc_src = 1'b0;
        run = 1'b1;
        instr_ready = 1'b1;
        repeat (20) tick();
        check("rand_progress", 64'(n_deliv > 200), 64'd1);
`ifdef FETCH_PERF_EN
        check("rand_stall_cnt", {32'h0, stall_cnt}, 64'(stall_m));
`else
        check("rand_stall_cnt", {32'h0, stall_cnt}, 64'd0);
        check("rand_flush_cnt", {32'h0, flush_cnt}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the fetch stage. Owns the program counter and issues one instruction-memory read at a time using a req/ack handshake. Buffers returned instructions in a small FIFO for the decode stage. On a branch redirect it flushes the FIFO and discards any stale in-flight response. It sits between the branch-resolution logic (pc_src/branch_target) and decode.

Parameters:
ADDR_W, 64, PC and memory address width (matches `WORD)
INSTR_W, 32, instruction width (matches `INSTR_LEN)
RESET_PC, 0, PC value loaded on reset
BUF_DEPTH, 2, instruction FIFO entries; power of two, minimum 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  fetch enable; 0 means no new requests are issued
pc_src  in  1  branch redirect strobe, one cycle
branch_target  in  ADDR_W  redirect PC, sampled when pc_src=1
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  request address
mem_ack  in  1  read data valid; completes the request
mem_rdata  in  INSTR_W  read data
instr_valid  out  1  FIFO head valid
instruction  out  INSTR_W  FIFO head instruction
instr_pc  out  ADDR_W  PC of the FIFO head
instr_ready  in  1  decode accepts the head
cur_pc  out  ADDR_W  next PC to be requested
stall_cnt  out  32  performance counter (see Optional Feature)
flush_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cur_pc=RESET_PC, FIFO empty.
  - mem_req=0, mem_addr=0, instr_valid=0, instruction=0, instr_pc=0.
  - Counters=0.
- States: IDLE, REQ, WAIT, DROP.
- IDLE -> REQ when run=1 and a FIFO slot is free (count < BUF_DEPTH). A slot is never reserved for more than one outstanding request.
- REQ:
  - Drive mem_req=1 and mem_addr=cur_pc.
  - Go to WAIT next cycle.
  - mem_req and mem_addr stay stable until mem_ack.
- WAIT on mem_ack=1:
  - Push {cur_pc, mem_rdata} into the FIFO and set cur_pc <= cur_pc+4 (wraps mod 2^ADDR_W).
  - mem_req drops in the same edge.
  - Next state is REQ if run=1 and a slot is free after this cycle's push/pop; otherwise IDLE.
  - Back-to-back fetch costs 2 cycles per instruction minimum (zero-wait memory).
- mem_ack is ignored in IDLE and REQ. Memory must not assert it before seeing mem_req in WAIT.
- Redirect (pc_src=1), any state:
  - cur_pc <= branch_target and the FIFO is flushed (count=0, instr_valid=0 next cycle).
  - A pop in the same cycle is overridden by the flush.
  - IDLE/REQ: the request is withdrawn and the next state is REQ at the target, provided run=1.
  - WAIT with mem_ack=0: go to DROP. mem_req stays high until the stale ack arrives, with data discarded.
  - WAIT with mem_ack=1 in the same cycle: data discarded, cur_pc=target, next state REQ.
  - DROP with mem_ack=1: discard the data and go to REQ, or IDLE if run=0. cur_pc is not incremented.
  - A redirect while in DROP only updates cur_pc; the state stays DROP.
- FIFO:
  - Pop when instr_valid & instr_ready.
  - A simultaneous push and pop keeps the count unchanged.
  - Push into a full FIFO is impossible by the slot rule.
  - instruction and instr_pc are the registered head; they are not updated combinationally from mem_rdata.
- run=0 stops new requests only. An outstanding request completes normally.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined:
  - stall_cnt increments each cycle instr_valid=1 and instr_ready=0.
  - flush_cnt increments by the number of valid entries discarded on a redirect, plus 1 if a response is dropped (WAIT/DROP).
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0, no counter logic is built, and the port list is unchanged.

Test Plan:
- Reset release with run=1, zero-wait memory returning data=addr[31:0]:
  - mem_addr sequence 0,4,8.
  - instr_valid first rises in cycle 3.
  - instr_pc/instruction pairs are 0/0x0, 4/0x4.
- instr_ready=0 with BUF_DEPTH=2: fetch stops after 2 entries (mem_req=0, cur_pc=8). After one pop, a single request to 8 is issued.
- pc_src=1 with branch_target=0x100 while in WAIT (3-cycle memory latency):
  - The stale ack data is discarded and the FIFO is empty.
  - The next mem_addr is 0x100.
  - With FETCH_PERF_EN, flush_cnt counts the discarded FIFO entries plus 1 for the dropped response.
- pc_src=1 in the same cycle as mem_ack, target 0x40: nothing is pushed, and the next request address is 0x40.
- Async reset asserted mid-WAIT: mem_req=0 immediately and cur_pc=RESET_PC. After release, fetch restarts at RESET_PC.
- cur_pc=0xFFFF_FFFF_FFFF_FFFC fetch: the next mem_addr is 0 (wrap).
